// File: rtl/mips_pkg.sv
// Shared EX-stage definitions: ALU opcodes, multiply sequencer states, datapath width.
package mips_pkg;

    localparam int unsigned WIDTH = 32;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_SLT = 4'b0100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mul_state_e;

endpackage

// File: rtl/mul_seq.sv
// Multi-cycle unsigned WIDTHxWIDTH multiply that borrows the shared EX-stage ALU adder.
module mul_seq
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = mips_pkg::WIDTH,
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [WIDTH-1:0] alu_result,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_ctrl,
    output logic             alu_sel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    mul_state_e       state_q, state_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic             alu_sel_q, alu_sel_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             carry;

    // Next state, shift-add datapath and registered output values
    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        mcand_d   = mcand_q;
        count_d   = count_q;
        // ALU has no carry-out; an unsigned wrap of hi + mcand shows up as result < hi
        carry     = (alu_result < hi_q);

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mcand_d = op_a;
                    count_d = '0;
                    hi_d    = '0;
                    if ((op_a == '0) || (op_b == '0)) begin
                        lo_d    = '0;
                        state_d = ST_DONE;
                    end else begin
                        lo_d    = op_b;
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (lo_q[0]) begin
                    hi_d = {carry, alu_result[WIDTH-1:1]};
                    lo_d = {alu_result[0], lo_q[WIDTH-1:1]};
                end else begin
                    hi_d = {1'b0, hi_q[WIDTH-1:1]};
                    lo_d = {hi_q[0], lo_q[WIDTH-1:1]};
                end
                count_d = count_q + CNT_W'(1);
                if (count_q == LAST_ITER) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs follow the upcoming state so alu_a tracks hi on every RUN cycle
        busy_d    = (state_d != ST_IDLE);
        done_d    = (state_d == ST_DONE);
        alu_sel_d = (state_d == ST_RUN);
        alu_a_d   = (state_d == ST_RUN) ? hi_d    : '0;
        alu_b_d   = (state_d == ST_RUN) ? mcand_d : '0;
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            hi_q      <= '0;
            lo_q      <= '0;
            mcand_q   <= '0;
            count_q   <= '0;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_sel_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            mcand_q   <= mcand_d;
            count_q   <= count_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            alu_sel_q <= alu_sel_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign alu_a    = alu_a_q;
    assign alu_b    = alu_b_q;
    assign alu_ctrl = ALU_ADD;
    assign alu_sel  = alu_sel_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule
